// File: rtl/imem_pkg.sv
// Shared types and constants for the pipelined instruction memory.
// Parity storage is enabled by defining IMEM_PARITY_EN.
package imem_pkg;

  localparam logic [15:0] IMEM_HALT = 16'hFFFF;
  localparam int IMEM_LAT_MIN = 1;
  localparam int IMEM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    PROG
  } imem_state_t;

  function automatic bit imem_lat_ok(input int lat);
    return (lat >= IMEM_LAT_MIN) && (lat <= IMEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch, read-return and program-load bundle between IF stage and imem.
// master = IF stage / loader side, slave = memory side.
interface imem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              rd_stall;
  logic              flush;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_oor;
  logic              rd_perr;
  logic              prog_en;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_inj;
  logic              prog_mode;

  modport master (
    output if_req, if_addr, rd_stall, flush,
    output prog_en, prog_we, prog_addr,
    output prog_data, prog_inj,
    input  if_ready, rd_valid, rd_data,
    input  rd_addr, rd_oor, rd_perr, prog_mode
  );

  modport slave (
    input  if_req, if_addr, rd_stall, flush,
    input  prog_en, prog_we, prog_addr,
    input  prog_data, prog_inj,
    output if_ready, rd_valid, rd_data,
    output rd_addr, rd_oor, rd_perr, prog_mode
  );

endinterface

// File: rtl/imem_rd_pipe.sv
// LATENCY-deep read return pipeline: valid/addr/data/flags per stage,
// holds on stall, clears valids on flush; last stage is the output.
module imem_rd_pipe
  import imem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int LATENCY = 1,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(IMEM_HALT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_oor,
  input  logic              in_perr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_oor,
  output logic              out_perr,
  output logic              any_valid
);

  logic [LATENCY-1:0] v;
  logic [LATENCY-1:0] o;
  logic [LATENCY-1:0] p;
  logic [ADDR_W-1:0]  a [LATENCY];
  logic [DATA_W-1:0]  d [LATENCY];
  logic               adv;

  assign adv = flush || !stall;

  // Payload only moves with a valid word, so the output holds between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      o <= '0;
      p <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        a[i] <= '0;
        d[i] <= HALT_WORD;
      end
    end else if (adv) begin
      v[0] <= in_valid;
      if (in_valid) begin
        a[0] <= in_addr;
        d[0] <= in_data;
        o[0] <= in_oor;
        p[0] <= in_perr;
      end
      for (int i = 1; i < LATENCY; i++) begin
        v[i] <= v[i-1] && !flush;
        if (v[i-1] && !flush) begin
          a[i] <= a[i-1];
          d[i] <= d[i-1];
          o[i] <= o[i-1];
          p[i] <= p[i-1];
        end
      end
    end
  end

  assign out_valid = v[LATENCY-1];
  assign out_addr  = a[LATENCY-1];
  assign out_data  = d[LATENCY-1];
  assign out_oor   = v[LATENCY-1] && o[LATENCY-1];
  assign out_perr  = v[LATENCY-1] && p[LATENCY-1];
  assign any_valid = |v;

endmodule

// File: rtl/imem_pipelined.sv
// Synchronous IF-stage instruction memory with runtime program load.
// Define IMEM_PARITY_EN to store and check a per-word even-parity bit.
module imem_pipelined
  import imem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 256,
  parameter int LATENCY = 1,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(IMEM_HALT)
) (
  input logic   clk,
  input logic   rst_n,
  imem_if.slave bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!imem_lat_ok(LATENCY)) begin : g_bad_lat
    $error("imem_pipelined: LATENCY out of range");
  end

  imem_state_t       state;
  logic              prog_mode_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              fetch_in;
  logic              prog_in;
  logic              wr_en;
  logic              any_valid;
  logic [IW-1:0]     f_idx;
  logic [IW-1:0]     p_idx;
  logic [DATA_W-1:0] f_word;
  logic [DATA_W-1:0] f_data;
  logic              f_perr;

  assign bus.if_ready = (state == RUN) && !bus.rd_stall;
  assign accept   = bus.if_req && bus.if_ready;
  assign fetch_in = {1'b0, bus.if_addr} < (ADDR_W+1)'(DEPTH);
  assign prog_in  = {1'b0, bus.prog_addr} < (ADDR_W+1)'(DEPTH);
  assign f_idx    = bus.if_addr[IW-1:0];
  assign p_idx    = bus.prog_addr[IW-1:0];
  assign f_word   = mem[f_idx];
  assign wr_en    = (state == PROG) && bus.prog_we && prog_in;

  // Array is deliberately not reset so a reset keeps loaded code.
  always_ff @(posedge clk) begin
    if (wr_en) mem[p_idx] <= bus.prog_data;
  end

`ifdef IMEM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par[p_idx] <= (^bus.prog_data) ^ bus.prog_inj;
  end

  assign f_perr = fetch_in && ((^f_word) != par[f_idx]);
`else
  logic unused_inj;

  assign unused_inj = bus.prog_inj;
  assign f_perr     = 1'b0;
`endif

  assign f_data = (!fetch_in || f_perr) ? HALT_WORD : f_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      prog_mode_q <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.prog_en) state <= DRAIN;
        end
        DRAIN: begin
          if (!bus.prog_en) begin
            state <= RUN;
          end else if (!any_valid) begin
            state       <= PROG;
            prog_mode_q <= 1'b1;
          end
        end
        PROG: begin
          if (!bus.prog_en) begin
            state       <= RUN;
            prog_mode_q <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          prog_mode_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prog_mode = prog_mode_q;

  imem_rd_pipe #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .LATENCY  (LATENCY),
    .HALT_WORD(HALT_WORD)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (bus.rd_stall),
    .flush    (bus.flush),
    .in_valid (accept),
    .in_addr  (bus.if_addr),
    .in_data  (f_data),
    .in_oor   (!fetch_in),
    .in_perr  (f_perr),
    .out_valid(bus.rd_valid),
    .out_addr (bus.rd_addr),
    .out_data (bus.rd_data),
    .out_oor  (bus.rd_oor),
    .out_perr (bus.rd_perr),
    .any_valid(any_valid)
  );

endmodule

// File: tb/tb_imem_pipelined.sv
// Bench for imem_pipelined: queue-based fetch model, per-cycle compare,
// directed literal scenarios and a randomized phase.
module tb_imem_pipelined;

  localparam int LAT = 2;
  localparam int DEPTH = 256;

`ifdef IMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  imem_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  imem_pipelined #(
    .DATA_W   (16),
    .ADDR_W   (16),
    .DEPTH    (DEPTH),
    .LATENCY  (LAT),
    .HALT_WORD(16'hFFFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: memory image, mode (0 RUN,1 DRAIN,2 PROG),
  // in-flight fetches with their age in advancing edges.
  logic [15:0] mm [DEPTH];
  bit          bad [DEPTH];
  int          mode = 0;
  int unsigned pa [$];
  int          pg [$];
  bit          m_valid = 1'b0;
  bit          m_oor = 1'b0;
  bit          m_perr = 1'b0;
  logic [15:0] m_data = 16'hFFFF;
  logic [15:0] m_addr = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_out();
    m_valid = 1'b0;
    m_oor   = 1'b0;
    m_perr  = 1'b0;
  endtask

  task automatic retire();
    int unsigned a;
    a = pa.pop_front();
    void'(pg.pop_front());
    m_valid = 1'b1;
    m_addr  = a[15:0];
    m_oor   = 1'b0;
    m_perr  = 1'b0;
    if (a >= DEPTH) begin
      m_data = 16'hFFFF;
      m_oor  = 1'b1;
    end else if (PAR && bad[a]) begin
      m_data = 16'hFFFF;
      m_perr = 1'b1;
    end else begin
      m_data = mm[a];
    end
  endtask

  task automatic model_edge();
    bit any;
    bit acc;
    bit adv;
    any = (pa.size() != 0) || m_valid;
    acc = bus.if_req && (mode == 0) && !bus.rd_stall;
    adv = bus.flush || !bus.rd_stall;
    if (mode == 2 && bus.prog_we && bus.prog_addr < DEPTH) begin
      mm[bus.prog_addr]  = bus.prog_data;
      bad[bus.prog_addr] = bus.prog_inj;
    end
    if (bus.flush) begin
      pa.delete();
      pg.delete();
    end else if (!bus.rd_stall) begin
      foreach (pg[i]) pg[i]++;
    end
    if (adv) clear_out();
    if (acc) begin
      pa.push_back(32'(bus.if_addr));
      pg.push_back(1);
    end
    if (adv && pg.size() != 0 && pg[0] == LAT) retire();
    case (mode)
      0: if (bus.prog_en) mode = 1;
      1: if (!bus.prog_en) mode = 0; else if (!any) mode = 2;
      default: if (!bus.prog_en) mode = 0;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode = 0;
      pa.delete();
      pg.delete();
      clear_out();
      m_data = 16'hFFFF;
      m_addr = 16'h0000;
    end else begin
      model_edge();
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rd_valid", bus.rd_valid, m_valid);
      chk("rd_data", bus.rd_data, m_data);
      chk("rd_addr", bus.rd_addr, m_addr);
      chk("rd_oor", bus.rd_oor, m_oor);
      chk("rd_perr", bus.rd_perr, m_perr);
      chk("prog_mode", bus.prog_mode, mode == 2);
      chk("if_ready", bus.if_ready, (mode == 0) && !bus.rd_stall);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.rd_stall  = 1'b0;
    bus.flush     = 1'b0;
    bus.prog_en   = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_inj  = 1'b0;
  endtask

  task automatic enter_prog();
    int n;
    n = 0;
    bus.prog_en = 1'b1;
    while (!bus.prog_mode && n < 12) begin
      step();
      n++;
    end
    chk("enter_prog", bus.prog_mode, 1);
  endtask

  task automatic pwrite(input int a, input logic [15:0] d, input bit inj);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 16'(a);
    bus.prog_data = d;
    bus.prog_inj  = inj;
    step();
    bus.prog_we  = 1'b0;
    bus.prog_inj = 1'b0;
  endtask

  task automatic leave_prog();
    bus.prog_en = 1'b0;
    step();
  endtask

  task automatic fetch(input int a);
    bus.if_req  = 1'b1;
    bus.if_addr = 16'(a);
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_data", bus.rd_data, 16'hFFFF);
    chk("rst_addr", bus.rd_addr, 0);
    chk("rst_mode", bus.prog_mode, 0);
    chk("rst_ready", bus.if_ready, 1);

    enter_prog();
    for (int i = 0; i < DEPTH; i++) begin
      logic [15:0] d;
      if (i < 4) d = 16'h1001 + 16'(i);
      else if (i == 44) d = 16'h0A44;
      else d = 16'($urandom);
      pwrite(i, d, 1'b0);
    end
    pwrite(300, 16'hDEAD, 1'b0);
    leave_prog();

    for (int k = 0; k < 6; k++) begin
      if (k >= 2) begin
        chk("b2b_valid", bus.rd_valid, 1);
        chk("b2b_data", bus.rd_data, 16'h1001 + 16'(k - 2));
      end else begin
        chk("b2b_idle", bus.rd_valid, 0);
      end
      bus.if_req  = (k < 4);
      bus.if_addr = 16'(k);
      step();
    end
    bus.if_req = 1'b0;

    fetch(0);
    fetch(1);
    chk("fl_w0_addr", bus.rd_addr, 0);
    chk("fl_w0_data", bus.rd_data, 16'h1001);
    bus.flush = 1'b1;
    fetch(3);
    bus.flush  = 1'b0;
    bus.if_req = 1'b0;
    chk("fl_gap_valid", bus.rd_valid, 0);
    chk("fl_gap_hold", bus.rd_data, 16'h1001);
    step();
    chk("fl_tgt_valid", bus.rd_valid, 1);
    chk("fl_tgt_addr", bus.rd_addr, 3);
    chk("fl_tgt_data", bus.rd_data, 16'h1004);
    step();
    chk("fl_end_valid", bus.rd_valid, 0);

    fetch(0);
    fetch(1);
    fetch(2);
    chk("st_w1_addr", bus.rd_addr, 1);
    bus.rd_stall = 1'b1;
    bus.if_addr  = 16'd3;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("st_hold_valid", bus.rd_valid, 1);
      chk("st_hold_addr", bus.rd_addr, 1);
      chk("st_hold_data", bus.rd_data, 16'h1002);
    end
    bus.rd_stall = 1'b0;
    fetch(3);
    bus.if_req = 1'b0;
    chk("st_w2_addr", bus.rd_addr, 2);
    step();
    chk("st_w3_addr", bus.rd_addr, 3);
    chk("st_w3_data", bus.rd_data, 16'h1004);
    step();
    chk("st_end_valid", bus.rd_valid, 0);

    fetch(300);
    bus.if_req = 1'b0;
    step();
    chk("oor_valid", bus.rd_valid, 1);
    chk("oor_data", bus.rd_data, 16'hFFFF);
    chk("oor_flag", bus.rd_oor, 1);
    chk("oor_addr", bus.rd_addr, 300);
    step();
    chk("oor_clear", bus.rd_oor, 0);
    fetch(44);
    bus.if_req = 1'b0;
    step();
    chk("alias_data", bus.rd_data, 16'h0A44);

    fetch(0);
    bus.prog_en = 1'b1;
    fetch(1);
    bus.if_addr = 16'd2;
    chk("dr_w0_data", bus.rd_data, 16'h1001);
    chk("dr_ready", bus.if_ready, 0);
    step();
    bus.if_req = 1'b0;
    chk("dr_w1_data", bus.rd_data, 16'h1002);
    chk("dr_w1_addr", bus.rd_addr, 1);
    step();
    chk("dr_empty", bus.rd_valid, 0);
    chk("dr_mode_lo", bus.prog_mode, 0);
    step();
    chk("dr_mode_hi", bus.prog_mode, 1);
    pwrite(2, 16'h2222, 1'b0);
    rst_n       = 1'b0;
    bus.prog_en = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rr_mode", bus.prog_mode, 0);
    chk("rr_valid", bus.rd_valid, 0);
    chk("rr_data", bus.rd_data, 16'hFFFF);
    fetch(2);
    bus.if_req = 1'b0;
    step();
    chk("rr_keep", bus.rd_data, 16'h2222);

    enter_prog();
    pwrite(5, 16'h5555, 1'b1);
    pwrite(6, 16'h6666, 1'b0);
    leave_prog();
    fetch(5);
    fetch(6);
    bus.if_req = 1'b0;
`ifdef IMEM_PARITY_EN
    chk("par_data", bus.rd_data, 16'hFFFF);
    chk("par_perr", bus.rd_perr, 1);
`else
    chk("par_data", bus.rd_data, 16'h5555);
    chk("par_perr", bus.rd_perr, 0);
`endif
    step();
    chk("par_ok_data", bus.rd_data, 16'h6666);
    chk("par_ok_perr", bus.rd_perr, 0);
    step();

    for (int n = 0; n < 2500; n++) begin
      bus.if_req   = ($urandom_range(9) < 7);
      bus.if_addr  = 16'($urandom_range(319));
      bus.rd_stall = ($urandom_range(99) < 15);
      bus.flush    = ($urandom_range(99) < 8);
      if (!bus.prog_en) bus.prog_en = ($urandom_range(99) < 2);
      else bus.prog_en = ($urandom_range(99) >= 6);
      bus.prog_we   = 1'($urandom_range(1));
      bus.prog_addr = 16'($urandom_range(299));
      bus.prog_data = 16'($urandom);
      bus.prog_inj  = ($urandom_range(9) == 0);
      step();
    end
    idle();
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
